div: RTL and testbench

Multi-cycle 32-bit integer divider serving the EX stage as a request/response co-processor for DIV/DIVU. EX raises a start request with operands and holds it, stalling the pipeline, until the divider returns a 64-bit {remainder, quotient} with a ready flag. EX then writes the result into HI/LO. One quotient bit is produced per cycle by restoring division.

---
 rtl/div.sv | 155 +++++++++++++++
 tb/tb_div.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) for the EX stage; result is {remainder, quotient}.
// Optional macro DIV_ANNUL_EN lets annul_i cancel an in-flight or presented division.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [32:0] rem;
    logic [31:0] quo;
    logic        sign1;
    logic        sign2;
    logic        signed_q;

    logic        abort;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

`ifdef DIV_ANNUL_EN
    assign abort = annul_i;
`else
    assign abort = 1'b0;
`endif

    // 32'h8000_0000 negates to itself, which is its correct unsigned magnitude.
    assign abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    assign shifted = {rem[31:0], dividend[31]};
    assign diff    = shifted - {1'b0, divisor};

    assign quo_fix = (signed_q && (sign1 ^ sign2)) ? (~quo + 32'd1) : quo;
    assign rem_fix = (signed_q && sign1) ? (~rem[31:0] + 32'd1) : rem[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (start_i && !annul_i) begin
                    state_nxt = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_nxt = abort ? FREE : END;
            end
            ON: begin
                if (!start_i || abort) begin
                    state_nxt = FREE;
                end else if (cnt == 6'd31) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (!start_i || abort) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    // ready_o/result_o are registered while in END, so they appear one edge after END entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            signed_q <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (state_nxt == ON) begin
                        dividend <= abs1;
                        divisor  <= abs2;
                        sign1    <= opdata1_i[31];
                        sign2    <= opdata2_i[31];
                        signed_q <= signed_div_i;
                        cnt      <= '0;
                        rem      <= '0;
                        quo      <= '0;
                    end
                end
                BYZERO: begin
                    rem      <= '0;
                    quo      <= '0;
                    signed_q <= 1'b0;
                end
                ON: begin
                    if (state_nxt != FREE) begin
                        dividend <= {dividend[30:0], 1'b0};
                        cnt      <= cnt + 6'd1;
                        if (!diff[32]) begin
                            rem <= diff;
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= shifted;
                            quo <= {quo[30:0], 1'b0};
                        end
                    end
                end
                END: begin
                    if (state_nxt == END) begin
                        ready_o  <= 1'b1;
                        result_o <= {rem_fix, quo_fix};
                    end else begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected {rem, quo} and latency; a negedge monitor checks.
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div = 1'b0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [63:0] result;
    logic        ready;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rises = 0;

    typedef struct {
        logic [63:0] res;
        int          e0;
        int          lat;
        string       name;
    } exp_t;

    exp_t sbq[$];

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: rising ready pops the scoreboard; held ready must be stable; falling ready clears result.
    logic        prev_ready = 1'b0;
    logic [63:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b1 && !prev_ready) begin
            rises++;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got ready=1 expected 0 (result %h)", result);
            end else begin
                e = sbq.pop_front();
                check64({e.name, "_result"}, result, e.res);
                check_int({e.name, "_latency"}, cyc - e.e0, e.lat);
            end
        end else if (ready === 1'b1 && prev_ready) begin
            check64("hold_stable", result, held);
        end else if (ready !== 1'b1 && prev_ready) begin
            check64("drop_result", result, 64'h0);
        end
        prev_ready = (ready === 1'b1);
        held       = result;
    end

    task automatic wait_ready(input string name);
        for (int n = 0; n < 60; n++) begin
            if (ready === 1'b1) break;
            @(negedge clk);
        end
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: got ready=%b expected 1", name, ready);
        end
    endtask

    task automatic do_req(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] res, input int lat);
        @(negedge clk);
        op1 = a;
        op2 = b;
        signed_div = sgn;
        start = 1'b1;
        sbq.push_back('{res, cyc + 1, lat, name});
        @(negedge clk);
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~sgn;
        wait_ready(name);
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int r0;
        repeat (3) @(negedge clk);
        check64("reset_result", result, 64'h0);
        check_int("reset_ready", int'(ready), 0);
        rst = 1'b1;
        @(negedge clk);

        do_req("udiv_100_7",    32'd100,        32'd7,          1'b0, {32'd2, 32'd14},               33);
        do_req("sdiv_m7_2",     32'hFFFF_FFF9,  32'h2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        do_req("sdiv_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, {32'h1, 32'hFFFF_FFFD},         33);
        do_req("udiv_m7_2",     32'hFFFF_FFF9,  32'h2,          1'b0, {32'h1, 32'h7FFF_FFFC},         33);
        do_req("sdiv_m100_m7",  32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, {32'hFFFF_FFFE, 32'd14},        33);
        do_req("udiv_max_1",    32'hFFFF_FFFF,  32'h1,          1'b0, {32'h0, 32'hFFFF_FFFF},         33);
        do_req("udiv_by_zero",  32'd5,          32'd0,          1'b0, 64'h0,                          2);
        do_req("sdiv_by_zero",  32'd5,          32'd0,          1'b1, 64'h0,                          2);
        do_req("sdiv_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0, 32'h8000_0000},         33);
        do_req("udiv_ovf_ops",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'h0},         33);

        // start dropped at iteration 10: no result
        @(negedge clk);
        r0 = rises;
        op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_int("abort_no_ready", rises, r0);

        // annul together with start in FREE: no request accepted
        r0 = rises;
        op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0; annul = 1'b0;
        repeat (40) @(negedge clk);
        check_int("annul_in_free", rises, r0);

        // annul pulse at iteration 20
        r0 = rises;
`ifdef DIV_ANNUL_EN
        op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (20) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_int("annul_cancels", rises, r0);
`else
        op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        sbq.push_back('{{32'd2, 32'd14}, cyc + 1, 33, "annul_ignored"});
        repeat (20) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        wait_ready("annul_ignored");
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_int("annul_ignored_rises", rises, r0 + 1);
`endif

        // asynchronous reset at iteration 15
        r0 = rises;
        op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_int("rst_mid_on_ready", int'(ready), 0);
        check64("rst_mid_on_result", result, 64'h0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_int("rst_mid_on_no_ready", rises, r0);
        do_req("after_reset_1000_10", 32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 33);

        // asynchronous reset while a result is presented
        @(negedge clk);
        op1 = 32'd9; op2 = 32'd4; signed_div = 1'b0; start = 1'b1;
        sbq.push_back('{{32'd1, 32'd2}, cyc + 1, 33, "udiv_9_4"});
        @(negedge clk);
        wait_ready("udiv_9_4");
        #2 rst = 1'b0;
        #1;
        check_int("rst_in_end_ready", int'(ready), 0);
        check64("rst_in_end_result", result, 64'h0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check_int("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
